// File: rtl/aes_round_sequencer.sv
// Iterative AES encryptor: one aesEnc round datapath reused for NR rounds.
// Round keys are fetched combinationally by index from an external key store.

module aesEnc (
  input  logic [127:0]          A,
  input  logic [127:0]          B,
  input  logic                  finalRound,
  output logic [3:0][3:0][7:0]  Y
);

  logic [3:0][3:0][7:0] w_sb;
  logic [3:0][3:0][7:0] w_sr;
  logic [3:0][3:0][7:0] w_mc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] inv;
    t   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    w_sb = '0;
    w_sr = '0;
    w_mc = '0;
    Y    = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_sb[i][j] = sbox(A[127-8*(4*j+i) -: 8]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_sr[i][j] = w_sb[i][(j+i)%4];
    for (int j = 0; j < 4; j++) begin
      w_mc[0][j] = xtime(w_sr[0][j]) ^ xtime(w_sr[1][j]) ^ w_sr[1][j] ^ w_sr[2][j] ^ w_sr[3][j];
      w_mc[1][j] = w_sr[0][j] ^ xtime(w_sr[1][j]) ^ xtime(w_sr[2][j]) ^ w_sr[2][j] ^ w_sr[3][j];
      w_mc[2][j] = w_sr[0][j] ^ w_sr[1][j] ^ xtime(w_sr[2][j]) ^ xtime(w_sr[3][j]) ^ w_sr[3][j];
      w_mc[3][j] = xtime(w_sr[0][j]) ^ w_sr[0][j] ^ w_sr[1][j] ^ w_sr[2][j] ^ xtime(w_sr[3][j]);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        Y[i][j] = (finalRound ? w_sr[i][j] : w_mc[i][j]) ^ B[127-8*(4*j+i) -: 8];
  end

endmodule

module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t               r_state;
  state_t               w_state_next;
  logic [127:0]         r_st_reg;
  logic [127:0]         w_st_next;
  logic [3:0]           r_round;
  logic [3:0]           w_round_next;
  logic                 w_final;
  logic [3:0][3:0][7:0] w_dp;
  logic [127:0]         w_dp_st;

  // finalRound must not stay high in DONE, where the round counter still reads NR.
  assign w_final = (r_state == ROUND) && (r_round == NR_L);

  aesEnc u_enc (
    .A          (r_st_reg),
    .B          (rk),
    .finalRound (w_final),
    .Y          (w_dp)
  );

  always_comb begin
    w_dp_st = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        w_dp_st[127-8*(4*j+i) -: 8] = w_dp[i][j];
  end

  always_comb begin
    w_state_next = r_state;
    w_st_next    = r_st_reg;
    w_round_next = r_round;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    rk_idx       = 4'd0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_st_next    = in_block ^ rk;
          w_round_next = 4'd1;
          w_state_next = ROUND;
        end
      end
      ROUND: begin
        rk_idx    = r_round;
        w_st_next = w_dp_st;
        if (r_round == NR_L) w_state_next = DONE;
        else                 w_round_next = r_round + 4'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the 128-bit state is reset too, so out_block reads 0 rather than stale data after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_round  <= 4'd0;
      r_st_reg <= '0;
    end else begin
      r_state  <= w_state_next;
      r_round  <= w_round_next;
      r_st_reg <= w_st_next;
    end
  end

  assign busy      = (r_state != IDLE);
  assign out_block = r_st_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vectors, random blocks against a
// byte-array AES model, plus backpressure, back-to-back and mid-run reset.

module tb_aes_round_sequencer;

  localparam int NR = 10;

  localparam logic [127:0] K_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  logic [127:0] rk_tab [0:15];
  logic [7:0]   sbox_t [0:255];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  // Key store model: combinational lookup by the requested index.
  assign rk = rk_tab[rk_idx];

  aes_round_sequencer #(.NR(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from the generator-3 walk of GF(2^8), independent of any inversion circuit.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^
                  {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk_tab[r] = '0;
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st;
    logic [127:0] kr;
    st = pt ^ rk_tab[0];
    for (int r = 1; r <= NR; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[st[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          n[4*c+rr] = s[4*((c+rr)%4)+rr];
      if (r != NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          n[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          n[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          n[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          n[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      kr = rk_tab[r];
      for (int k = 0; k < 16; k++) st[127-8*k -: 8] = n[k] ^ kr[127-8*k -: 8];
    end
    return st;
  endfunction

  // Offer one block, check the accept cycle, then scramble in_block after the accept edge.
  task automatic start_block(input string tag, input logic [127:0] key, input logic [127:0] pt);
    key_expand(key);
    @(negedge clk);
    in_valid = 1'b1;
    in_block = pt;
    check({tag, "_accept_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_accept_rk_idx"}, 128'(rk_idx), 128'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Called at the first negedge after the accept edge; returns cycles until out_valid.
  task automatic wait_done(input string tag, input bit trace, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (trace) check({tag, "_rk_idx"}, 128'(rk_idx), 128'(cyc + 1));
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] key,
                           input logic [127:0] pt, input logic [127:0] ct);
    int cyc;
    out_ready = 1'b1;
    start_block(tag, key, pt);
    wait_done(tag, 1'b1, cyc);
    check({tag, "_latency"}, 128'(cyc), 128'(NR));
    check({tag, "_out_block"}, out_block, ct);
    check({tag, "_done_rk_idx"}, 128'(rk_idx), 128'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_post_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_post_in_ready"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           cyc;
    int           acc_q [$];
    logic [127:0] out_q [$];

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b0;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    build_sbox();

    #1;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_block", out_block,       128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_rk_idx",    128'(rk_idx),    128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{key: K_B, pt: P_B, ct: C_B};
    vecs[1] = '{key: K_C, pt: P_C, ct: C_C};
    for (int v = 2; v < 6; v++) begin
      vecs[v].key = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[v].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_expand(vecs[v].key);
      vecs[v].ct  = model_encrypt(vecs[v].pt);
    end

    for (int v = 0; v < 6; v++)
      run_block($sformatf("vec%0d", v), vecs[v].key, vecs[v].pt, vecs[v].ct);

    // Backpressure: consumer stalls for 5 cycles while in_valid pulses are offered.
    out_ready = 1'b0;
    start_block("bp", K_C, P_C);
    wait_done("bp", 1'b0, cyc);
    check("bp_latency", 128'(cyc), 128'(NR));
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_out_valid%0d", k), 128'(out_valid), 128'd1);
      check($sformatf("bp_out_block%0d", k), out_block, C_C);
      check($sformatf("bp_in_ready%0d", k),  128'(in_ready),  128'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_release_busy",      128'(busy),      128'd0);
    check("bp_release_in_ready",  128'(in_ready),  128'd1);

    // Back-to-back: in_valid and out_ready held high for two blocks.
    key_expand(K_C);
    in_valid  = 1'b1;
    in_block  = P_C;
    out_ready = 1'b1;
    cyc = 0;
    while (out_q.size() < 2 && cyc < 40) begin
      if (acc_q.size() >= 2) in_valid = 1'b0;
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) out_q.push_back(out_block);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_q.size()), 128'd2);
    check("b2b_outputs", 128'(out_q.size()), 128'd2);
    if (acc_q.size() >= 2) check("b2b_spacing", 128'(acc_q[1] - acc_q[0]), 128'd12);
    if (out_q.size() >= 1) check("b2b_out0", out_q[0], C_C);
    if (out_q.size() >= 2) check("b2b_out1", out_q[1], C_C);
    repeat (2) @(negedge clk);

    // Reset while round 5 is being requested.
    out_ready = 1'b1;
    start_block("rst_mid", K_B, P_B);
    cyc = 0;
    while (rk_idx != 4'd5 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached_rk5", 128'(rk_idx), 128'd5);
    reset = 1'b1;
    #1;
    check("rst_mid_busy",      128'(busy),      128'd0);
    check("rst_mid_out_valid", 128'(out_valid), 128'd0);
    check("rst_mid_in_ready",  128'(in_ready),  128'd1);
    check("rst_mid_rk_idx",    128'(rk_idx),    128'd0);
    check("rst_mid_out_block", out_block,       128'd0);
    @(negedge clk);
    reset = 1'b0;
    run_block("after_rst", K_B, P_B, C_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
